branch_pc_sequencer: RTL
========================

Name: branch_pc_sequencer

Overview:
- Owns the fetch program counter and resolves branches for the ARM pipeline.
- Normal operation: PC advances by PC_STEP each cycle.
- A branch presented by the decode stage has its condition evaluated against the current NZCV flags.
- A taken branch computes the target as base + sign-extended 24-bit word offset, redirects fetch, flushes the wrong-path instruction and, for BL, raises a link-register write.
- Sits between the hazard unit, the IF/ID register and the register file write port.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- PC_STEP, 4, byte increment of sequential fetch.
- PIPE_OFFSET, 8, pipeline read-ahead added to the branch's own address when forming the target.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- stall_i  input  1  hazard unit hold; freezes PC and ignores branch_valid_i.
- branch_valid_i  input  1  decode stage presents a B/BL this cycle.
- branch_link_i  input  1  branch is BL; qualified by branch_valid_i.
- branch_cond_i  input  4  ARM condition field.
- flags_i  input  4  current {N,Z,C,V}.
- branch_offset_i  input  24  signed word offset (imm24).
- branch_pc_i  input  32  byte address of the branch instruction.
- pc_o  output  32  fetch address (registered).
- fetch_valid_o  output  1  fetch at pc_o is architecturally valid.
- flush_o  output  1  kill IF/ID contents this cycle (registered pulse).
- taken_o  output  1  one-cycle pulse: branch taken.
- link_we_o  output  1  one-cycle pulse: write link_addr_o to R14.
- link_addr_o  output  32  branch_pc_i + 4 captured at resolution.

Behaviour:
- Reset (async, any state):
  - pc_o=RESET_PC; fetch_valid_o=0.
  - flush_o, taken_o and link_we_o = 0; link_addr_o=0.
  - state=BOOT.
- BOOT:
  - Next edge: fetch_valid_o<=1, state<=RUN, pc_o unchanged (first fetch at RESET_PC).
  - branch_valid_i is ignored.
- RUN, stall_i=1:
  - pc_o holds and branch_valid_i is ignored; decode re-presents the branch after the stall.
  - All pulse outputs are 0.
- RUN, stall_i=0, no taken branch: pc_o<=pc_o+PC_STEP, modulo 2^32.
- RUN, stall_i=0, branch_valid_i=1, cond passes:
  - Next edge: pc_o<=target; flush_o, taken_o <=1 for exactly one cycle; state<=FLUSH.
  - If branch_link_i=1: link_we_o<=1 for one cycle and link_addr_o<=branch_pc_i+4.
- RUN, cond fails: behaves as sequential; no pulse outputs.
- FLUSH (one cycle):
  - pc_o<=pc_o+PC_STEP unless stall_i=1, in which case pc_o holds and state stays FLUSH.
  - branch_valid_i is ignored (the slot is a bubble).
  - Pulse outputs return to 0.
  - Next edge: state<=RUN.
- Target arithmetic:
  - target = branch_pc_i + PIPE_OFFSET + ({{6{off[23]}},off,2'b00}), 32-bit, wrap modulo 2^32.
  - Negative offsets are true two's-complement subtraction, with no off-by-one.
- Condition evaluation:
  - EQ Z; NE !Z; CS C; CC !C; MI N; PL !N; VS V; VC !V.
  - HI C&!Z; LS !C|Z; GE N==V; LT N!=V; GT !Z&(N==V); LE Z|(N!=V).
  - AL always; 4'hF (NV) never.
- Simultaneous stall_i and branch_valid_i: stall wins, and the branch is not resolved.
- Latency: resolution to redirected pc_o is 1 cycle; exactly one wrong-path fetch is flushed.

Decomposition:
- Shared package (arm_pipe_pkg):
  - 4-bit condition code constants COND_EQ..COND_NV.
  - Flag bit indices FLAG_N/Z/C/V.
  - Sequencer state enum {BOOT, RUN, FLUSH}.
- Sub-module: cond_eval, a combinational cond + flags -> pass check, reused later by the execute-stage predication.
- The target adder stays inline in the sequencer.

Test Plan:
- Reset and sequential fetch:
  - Assert reset mid-run, release.
  - Required: pc_o=0 with fetch_valid_o=0 for one cycle, then 0, 4, 8, 12 with fetch_valid_o=1.
- Forward BL, AL:
  - branch_pc_i=0x100, offset=0x000010, cond=E.
  - Next cycle: pc_o=0x148, flush_o=taken_o=link_we_o=1, link_addr_o=0x104.
  - Following cycle: pc_o=0x14C, pulses 0.
- Backward B with wraparound:
  - branch_pc_i=0x4, offset=0xFFFFF0 (-16).
  - Required: pc_o=0xFFFF_FFCC, no link_we_o.
- Condition sweep:
  - For all 16 conditions across all 16 NZCV values, compare taken_o with a reference table.
  - Example: EQ with Z=0 stays sequential with no pulses; NV never taken.
- Stall priority:
  - stall_i=1 with branch_valid_i=1 (AL) for 3 cycles: pc_o frozen, no pulses.
  - stall_i drops while the branch is still presented: redirect occurs on the next edge.
- Reset during FLUSH:
  - Assert reset in the cycle flush_o=1.
  - Required: all outputs clear immediately (async); pc_o=RESET_PC; BOOT sequence repeats.

Source files
------------

// File: rtl/arm_pipe_pkg.sv
// Shared ARM pipeline definitions: condition codes, flag indices
// and the fetch sequencer state type.
package arm_pipe_pkg;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;
  localparam logic [3:0] COND_NV = 4'hF;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    FLUSH
  } seqState_e;

endpackage

// File: rtl/cond_eval.sv
// ARM condition check: cond field + {N,Z,C,V} -> pass.
// Purely combinational so execute-stage predication can share it.
module cond_eval
  import arm_pipe_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       pass
);

  logic n;
  logic z;
  logic c;
  logic v;

  assign n = flags[FLAG_N];
  assign z = flags[FLAG_Z];
  assign c = flags[FLAG_C];
  assign v = flags[FLAG_V];

  always_comb begin
    pass = 1'b0;
    unique case (cond)
      COND_EQ: pass = z;
      COND_NE: pass = !z;
      COND_CS: pass = c;
      COND_CC: pass = !c;
      COND_MI: pass = n;
      COND_PL: pass = !n;
      COND_VS: pass = v;
      COND_VC: pass = !v;
      COND_HI: pass = c && !z;
      COND_LS: pass = !c || z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = !z && (n == v);
      COND_LE: pass = z || (n != v);
      COND_AL: pass = 1'b1;
      COND_NV: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_pc_sequencer.sv
// Fetch PC owner: sequential fetch, branch resolution, redirect,
// one-slot flush and BL link-register write request.
module branch_pc_sequencer
  import arm_pipe_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned PC_STEP     = 4,
  parameter int unsigned PIPE_OFFSET = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_i,
  input  logic        branch_valid_i,
  input  logic        branch_link_i,
  input  logic [3:0]  branch_cond_i,
  input  logic [3:0]  flags_i,
  input  logic [23:0] branch_offset_i,
  input  logic [31:0] branch_pc_i,
  output logic [31:0] pc_o,
  output logic        fetch_valid_o,
  output logic        flush_o,
  output logic        taken_o,
  output logic        link_we_o,
  output logic [31:0] link_addr_o
);

  seqState_e   state;
  seqState_e   stateNext;
  logic [31:0] pcNext;
  logic        validNext;
  logic        flushNext;
  logic        takenNext;
  logic        linkWeNext;
  logic [31:0] linkAddrNext;

  logic        condPass;
  logic [31:0] offExt;
  logic [31:0] target;
  logic [31:0] pcSeq;
  logic        resolve;

  cond_eval uCondEval (
    .cond  (branch_cond_i),
    .flags (flags_i),
    .pass  (condPass)
  );

  // imm24 is a word offset: sign-extend then scale to bytes
  assign offExt = {{6{branch_offset_i[23]}}, branch_offset_i, 2'b00};
  assign target = branch_pc_i + 32'(PIPE_OFFSET) + offExt;
  assign pcSeq  = pc_o + 32'(PC_STEP);

  // stall wins over a presented branch; decode re-presents it later
  assign resolve = (state == RUN) && !stall_i
                && branch_valid_i && condPass;

  always_comb begin
    stateNext    = state;
    pcNext       = pc_o;
    validNext    = fetch_valid_o;
    flushNext    = 1'b0;
    takenNext    = 1'b0;
    linkWeNext   = 1'b0;
    linkAddrNext = link_addr_o;
    unique case (state)
      BOOT: begin
        validNext = 1'b1;
        stateNext = RUN;
      end
      RUN: begin
        if (resolve) begin
          pcNext    = target;
          flushNext = 1'b1;
          takenNext = 1'b1;
          stateNext = FLUSH;
          if (branch_link_i) begin
            linkWeNext   = 1'b1;
            linkAddrNext = branch_pc_i + 32'd4;
          end
        end else if (!stall_i) begin
          pcNext = pcSeq;
        end
      end
      FLUSH: begin
        if (!stall_i) begin
          pcNext    = pcSeq;
          stateNext = RUN;
        end
      end
      default: stateNext = BOOT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= BOOT;
      pc_o          <= RESET_PC;
      fetch_valid_o <= 1'b0;
      flush_o       <= 1'b0;
      taken_o       <= 1'b0;
      link_we_o     <= 1'b0;
      link_addr_o   <= 32'd0;
    end else begin
      state         <= stateNext;
      pc_o          <= pcNext;
      fetch_valid_o <= validNext;
      flush_o       <= flushNext;
      taken_o       <= takenNext;
      link_we_o     <= linkWeNext;
      link_addr_o   <= linkAddrNext;
    end
  end

endmodule
